// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - PLL/init inputs and per-domain reset outputs of the reset sequencer
interface reset_sequencer_if #(
    parameter int N_DOMAINS = 4
);
    logic                 PLL_LOCK;
    logic                 INIT_DONE;
    logic                 SW_RST_REQ;
    logic [N_DOMAINS-1:0] DOMAIN_MASK;
    logic [N_DOMAINS-1:0] RESET_N;
    logic                 PLL_POWERDOWN_N;
    logic                 READY;
    logic [2:0]           STATE;
    logic [7:0]           LOCK_LOSS_CNT;

    modport master (
        input  PLL_LOCK, INIT_DONE, SW_RST_REQ, DOMAIN_MASK,
        output RESET_N, PLL_POWERDOWN_N, READY, STATE, LOCK_LOSS_CNT
    );

    modport slave (
        output PLL_LOCK, INIT_DONE, SW_RST_REQ, DOMAIN_MASK,
        input  RESET_N, PLL_POWERDOWN_N, READY, STATE, LOCK_LOSS_CNT
    );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - PLL power-down / lock qualification and staggered multi-domain reset release
module reset_sequencer #(
    parameter int N_DOMAINS    = 4,
    parameter int CNT_W        = 16,
    parameter int PD_CYCLES    = 64,
    parameter int LOCK_FILTER  = 32,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int STAGE_DELAY  = 256,
    parameter int LOSS_FILTER  = 4
) (
    input  logic               CLK,
    input  logic               RST,
    reset_sequencer_if.master  bus
);
    localparam int IDX_W = $clog2(N_DOMAINS + 1);

    localparam logic [CNT_W-1:0] PD_LAST   = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LF_LAST   = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SD_LAST   = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_FILTER - 1);

    typedef enum logic [2:0] {
        PWRDN     = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4,
        SWRST     = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     filt_q, filt_d;
    logic [CNT_W-1:0]     loss_q, loss_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_DOMAINS-1:0] mask_q, mask_d;
    logic [N_DOMAINS-1:0] reset_n_q, reset_n_d;
    logic                 pd_n_q, pd_n_d;
    logic                 ready_q, ready_d;
    logic [7:0]           llc_q, llc_d;
    logic                 lock_meta_q, lock_meta_d, lock_sync_q, lock_sync_d;
    logic                 init_meta_q, init_meta_d, init_sync_q, init_sync_d;

    logic loss_watch;
    logic lock_lost;
    logic both_high;
    logic cur_en;

    assign loss_watch = (state_q == RELEASE) || (state_q == RUN) || (state_q == SWRST);
    assign lock_lost  = loss_watch && !lock_sync_q && (loss_q == LOSS_LAST);
    assign both_high  = lock_sync_q && init_sync_q;

    always_comb begin
        lock_meta_d = bus.PLL_LOCK;
        lock_sync_d = lock_meta_q;
        init_meta_d = bus.INIT_DONE;
        init_sync_d = init_meta_q;
    end

    // Participation of the domain currently addressed by the release index
    always_comb begin
        cur_en = 1'b0;
        for (int k = 0; k < N_DOMAINS; k++) begin
            if (idx_q == IDX_W'(k)) cur_en = mask_q[k];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        filt_d    = '0;
        loss_d    = (loss_watch && !lock_sync_q) ? loss_q + CNT_W'(1) : '0;
        idx_d     = idx_q;
        mask_d    = mask_q;
        reset_n_d = reset_n_q;

        if (lock_lost) begin
            state_d = FAULT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                PWRDN: begin
                    if (cnt_q == PD_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (both_high && filt_q == LF_LAST) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                        mask_d  = bus.DOMAIN_MASK;
                    end else if (cnt_q == TMO_LAST) begin
                        state_d = PWRDN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (both_high) filt_d = filt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (bus.SW_RST_REQ) begin
                        state_d = SWRST;
                        cnt_d   = '0;
                    end else if (idx_q == IDX_W'(N_DOMAINS)) begin
                        state_d = RUN;
                    end else if (!cur_en) begin
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = '0;
                    end else if (cnt_q == SD_LAST) begin
                        for (int k = 0; k < N_DOMAINS; k++) begin
                            if (idx_q == IDX_W'(k)) reset_n_d[k] = 1'b1;
                        end
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (bus.SW_RST_REQ) begin
                        state_d = SWRST;
                        cnt_d   = '0;
                    end
                end
                SWRST: begin
                    if (cnt_q == SD_LAST) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                        mask_d  = bus.DOMAIN_MASK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                FAULT: begin
                    state_d = PWRDN;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = PWRDN;
                    cnt_d   = '0;
                end
            endcase
        end

        // Released bits survive only while releasing or running
        if (state_d != RELEASE && state_d != RUN) reset_n_d = '0;
    end

    assign pd_n_d  = (state_d != PWRDN);
    assign ready_d = (state_d == RUN);
    assign llc_d   = (state_d == FAULT && llc_q != 8'hFF) ? llc_q + 8'd1 : llc_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= PWRDN;
            cnt_q       <= '0;
            filt_q      <= '0;
            loss_q      <= '0;
            idx_q       <= '0;
            mask_q      <= '0;
            reset_n_q   <= '0;
            pd_n_q      <= 1'b0;
            ready_q     <= 1'b0;
            llc_q       <= 8'd0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            init_meta_q <= 1'b0;
            init_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
            loss_q      <= loss_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            reset_n_q   <= reset_n_d;
            pd_n_q      <= pd_n_d;
            ready_q     <= ready_d;
            llc_q       <= llc_d;
            lock_meta_q <= lock_meta_d;
            lock_sync_q <= lock_sync_d;
            init_meta_q <= init_meta_d;
            init_sync_q <= init_sync_d;
        end
    end

    assign bus.RESET_N         = reset_n_q;
    assign bus.PLL_POWERDOWN_N = pd_n_q;
    assign bus.READY           = ready_q;
    assign bus.STATE           = state_q;
    assign bus.LOCK_LOSS_CNT   = llc_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer against a timeline model
module tb_reset_sequencer;
    localparam int ND   = 4;
    localparam int PD   = 8;
    localparam int LF   = 4;
    localparam int TMO  = 100;
    localparam int SD   = 10;
    localparam int LOSS = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    reset_sequencer_if #(.N_DOMAINS(ND)) bus ();

    reset_sequencer #(
        .N_DOMAINS(ND), .CNT_W(16), .PD_CYCLES(PD), .LOCK_FILTER(LF),
        .LOCK_TIMEOUT(TMO), .STAGE_DELAY(SD), .LOSS_FILTER(LOSS)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: states use the documented encoding, m_t = edges spent in current state
    int         m_state, m_t, m_hi, m_low, m_llc;
    logic [3:0] m_mask, m_rn;
    logic       m_pd, m_ready;
    logic       sl1, sl2, si1, si2;
    bit         m_valid;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic lk, it;
        int   nxt, e, acc, hi_next;
        bit   watched;
        if (rst) begin
            m_state = 0; m_t = 0; m_hi = 0; m_low = 0; m_llc = 0;
            m_mask = '0; m_rn = '0; m_pd = 0; m_ready = 0;
            sl1 = 0; sl2 = 0; si1 = 0; si2 = 0;
            m_valid = 1;
            return;
        end
        lk = sl2; it = si2; nxt = m_state; e = m_t + 1; hi_next = 0;
        watched = (m_state == 2) || (m_state == 3) || (m_state == 5);
        m_low = (watched && !lk) ? m_low + 1 : 0;
        case (m_state)
            0: if (e == PD) nxt = 1;
            1: begin
                hi_next = (lk && it) ? m_hi + 1 : 0;
                if (hi_next == LF) nxt = 2;
                else if (e == TMO) nxt = 0;
            end
            2, 3, 5: begin
                if (m_low == LOSS) nxt = 4;
                else if (bus.SW_RST_REQ && m_state != 5) nxt = 5;
                else if (m_state == 2) begin
                    // stage k ends at the cumulative sum of stage lengths
                    acc = 0;
                    for (int k = 0; k < ND; k++) begin
                        acc += m_mask[k] ? SD : 1;
                        if (m_mask[k] && e >= acc) m_rn[k] = 1'b1;
                    end
                    if (e == acc + 1) nxt = 3;
                end else if (m_state == 5 && e == SD) nxt = 2;
            end
            default: nxt = 0;
        endcase
        m_hi = hi_next;
        if (nxt == 2 && m_state != 2) m_mask = bus.DOMAIN_MASK;
        if (nxt != 2 && nxt != 3) m_rn = '0;
        if (nxt == 4 && m_llc < 255) m_llc++;
        m_pd    = (nxt != 0);
        m_ready = (nxt == 3);
        m_t     = (nxt == m_state) ? m_t + 1 : 0;
        m_state = nxt;
        sl2 = sl1; sl1 = bus.PLL_LOCK;
        si2 = si1; si1 = bus.INIT_DONE;
    endtask

    initial begin
        cyc = 0;
        m_valid = 0;
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("cmp_reset_n", bus.RESET_N, m_rn);
                chk("cmp_pd_n", bus.PLL_POWERDOWN_N, m_pd);
                chk("cmp_ready", bus.READY, m_ready);
                chk("cmp_state", bus.STATE, m_state);
                chk("cmp_llc", bus.LOCK_LOSS_CNT, m_llc);
            end
        end
    end

    function automatic logic [31:0] sig_val(input int which);
        case (which)
            0:          return 32'(bus.PLL_POWERDOWN_N);
            1, 2, 3, 4: return 32'(bus.RESET_N[which-1]);
            5:          return 32'(bus.READY);
            default:    return 32'(bus.STATE);
        endcase
    endfunction

    task automatic wait_sig(input string nm, input int which, input int val, input int lim, output int at);
        bit hit;
        hit = 0;
        at  = -1;
        for (int n = 0; n < lim && !hit; n++) begin
            @(negedge clk);
            if (sig_val(which) == 32'(val)) begin
                hit = 1;
                at  = cyc;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s timeout: got no event within %0d cycles, required value %0d", nm, lim, val);
        end
    endtask

    int t0, at, tp, tr;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.PLL_LOCK    = 1'b1;
        bus.INIT_DONE   = 1'b1;
        bus.SW_RST_REQ  = 1'b0;
        bus.DOMAIN_MASK = 4'b1111;
        repeat (3) @(negedge clk);
        chk("rst_reset_n", bus.RESET_N, 0);
        chk("rst_pd_n", bus.PLL_POWERDOWN_N, 0);
        chk("rst_ready", bus.READY, 0);
        chk("rst_state", bus.STATE, 0);
        chk("rst_llc", bus.LOCK_LOSS_CNT, 0);

        // clean bring-up
        rst = 1'b0; t0 = cyc;
        wait_sig("t1_pd", 0, 1, 20, at);    chk("t1_pd_rise", at - t0, 8);
        wait_sig("t1_rn0", 1, 1, 40, at);   chk("t1_rn0_rise", at - t0, 22);
        wait_sig("t1_rn1", 2, 1, 40, at);   chk("t1_rn1_rise", at - t0, 32);
        wait_sig("t1_rn2", 3, 1, 40, at);   chk("t1_rn2_rise", at - t0, 42);
        wait_sig("t1_rn3", 4, 1, 40, at);   chk("t1_rn3_rise", at - t0, 52);
        wait_sig("t1_ready", 5, 1, 5, at);  chk("t1_ready_rise", at - t0, 53);
        chk("t1_state_run", bus.STATE, 3);
        chk("t1_model_run", m_state, 3);

        // lock loss: 1-cycle glitch ignored, 3-cycle drop faults
        repeat (5) @(negedge clk);
        bus.PLL_LOCK = 1'b0;
        @(negedge clk) bus.PLL_LOCK = 1'b1;
        repeat (10) @(negedge clk);
        chk("t3_glitch_state", bus.STATE, 3);
        bus.PLL_LOCK = 1'b0;
        repeat (3) @(negedge clk);
        bus.PLL_LOCK = 1'b1;
        wait_sig("t3_fault", 6, 4, 10, at);
        chk("t3_fault_rn", bus.RESET_N, 0);
        chk("t3_fault_ready", bus.READY, 0);
        chk("t3_fault_pd", bus.PLL_POWERDOWN_N, 1);
        @(negedge clk);
        chk("t3_pwrdn_state", bus.STATE, 0);
        chk("t3_pwrdn_pd", bus.PLL_POWERDOWN_N, 0);
        chk("t3_llc", bus.LOCK_LOSS_CNT, 1);
        wait_sig("t3_rerun", 6, 3, 200, at);

        // software reset in RUN
        @(negedge clk) bus.SW_RST_REQ = 1'b1; tp = cyc;
        @(negedge clk) bus.SW_RST_REQ = 1'b0;
        chk("t4_state_swrst", bus.STATE, 5);
        chk("t4_rn_low", bus.RESET_N, 0);
        chk("t4_ready_low", bus.READY, 0);
        chk("t4_pd_high", bus.PLL_POWERDOWN_N, 1);
        wait_sig("t4_rn0", 1, 1, 40, at);   chk("t4_rn0_rise", at - tp, 21);
        wait_sig("t4_run", 6, 3, 100, at);
        chk("t4_llc", bus.LOCK_LOSS_CNT, 1);

        // masking 1010 applied through a software re-release
        bus.DOMAIN_MASK = 4'b1010;
        bus.SW_RST_REQ = 1'b1; tp = cyc;
        @(negedge clk) bus.SW_RST_REQ = 1'b0;
        wait_sig("t5_release", 6, 2, 30, tr);   chk("t5_release_entry", tr - tp, 11);
        wait_sig("t5_rn1", 2, 1, 30, at);       chk("t5_rn1_rise", at - tr, 11);
        tr = at;
        wait_sig("t5_rn3", 4, 1, 30, at);       chk("t5_rn3_rise", at - tr, 11);
        wait_sig("t5_run", 6, 3, 5, at);
        chk("t5_rn_masked", bus.RESET_N, 4'b1010);
        bus.DOMAIN_MASK = 4'b1111;
        repeat (5) @(negedge clk);
        chk("t5_mask_in_run", bus.RESET_N, 4'b1010);

        // SW request on the second low lock sample: lock loss wins
        bus.PLL_LOCK = 1'b0;
        repeat (3) @(negedge clk);
        bus.SW_RST_REQ = 1'b1;
        @(negedge clk) bus.SW_RST_REQ = 1'b0;
        chk("t6_prio_state", bus.STATE, 4);
        chk("t6_prio_llc", bus.LOCK_LOSS_CNT, 2);
        bus.PLL_LOCK = 1'b1;

        // saturation of the lock-loss counter
        for (int i = 0; i < 260; i++) begin
            wait_sig("t6_sat_release", 6, 2, 200, at);
            bus.PLL_LOCK = 1'b0;
            wait_sig("t6_sat_fault", 6, 4, 20, at);
            bus.PLL_LOCK = 1'b1;
        end
        chk("t6_llc_sat", bus.LOCK_LOSS_CNT, 255);
        chk("t6_model_llc_sat", m_llc, 255);

        // RST while releasing
        wait_sig("t6_rst_release", 6, 2, 200, at);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_rn", bus.RESET_N, 0);
        chk("t6_rst_pd", bus.PLL_POWERDOWN_N, 0);
        chk("t6_rst_ready", bus.READY, 0);
        chk("t6_rst_state", bus.STATE, 0);
        chk("t6_rst_llc", bus.LOCK_LOSS_CNT, 0);

        // lock timeout
        bus.PLL_LOCK = 1'b0;
        @(negedge clk) rst = 1'b0; t0 = cyc;
        wait_sig("t2_pd_up", 0, 1, 20, at);     chk("t2_pd_rise", at - t0, 8);
        wait_sig("t2_pd_down", 0, 0, 120, at);  chk("t2_pd_fall", at - t0, 108);
        chk("t2_state_pwrdn", bus.STATE, 0);
        wait_sig("t2_pd_up2", 0, 1, 20, at);    chk("t2_pd_rise2", at - t0, 116);
        chk("t2_state_wait", bus.STATE, 1);
        chk("t2_llc", bus.LOCK_LOSS_CNT, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
